// File: rtl/flash_seq.sv
// rtl/flash_seq.sv - NAND flash pin sequencer: CMD/ADDR/DIN/DOUT beats, ready/busy wait, write protect
// Optional busy-wait timeout enabled by defining FLASH_SEQ_TIMEOUT_EN.
module flash_seq #(
  parameter int DW     = 8,
  parameter int NUM_CE = 2,
  parameter int T_LO   = 2,
  parameter int T_HI   = 2,
  parameter int T_TO   = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [2:0]        ins_mode,
  input  logic [11:0]       ins_count,
  input  logic [1:0]        ins_ce,
  input  logic [DW-1:0]     wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic [NUM_CE-1:0] oCE_N,
  output logic              oCLE,
  output logic              oALE,
  output logic              oWE_N,
  output logic              oRE_N,
  output logic              oWP_N,
  input  logic              iRB_N,
  input  logic [DW-1:0]     flash_q,
  output logic [DW-1:0]     flash_data,
  output logic              data_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_DATA, S_STROBE_LO, S_STROBE_HI, S_WAIT_RB
  } state_t;

  localparam logic [2:0] M_CMD = 3'd0, M_ADDR = 3'd1, M_DOUT = 3'd3, M_WAIT_RB = 3'd4,
                         M_WP_ON = 3'd5, M_WP_OFF = 3'd6, M_RSVD = 3'd7;
  localparam logic [DW-1:0] IDLE_PAT = {(DW/8){8'hAA}};
  localparam logic [3:0]    LO_INIT  = 4'(T_LO - 1);
  localparam logic [3:0]    HI_INIT  = 4'(T_HI - 1);

  state_t        state;
  logic [2:0]    mode;
  logic [11:0]   beats;
  logic [1:0]    ce_idx;
  logic [1:0]    ce_sel;
  logic          ce_switch;
  logic [3:0]    tmr;
  logic [DW-1:0] wdata_q;

  function automatic logic [NUM_CE-1:0] ce_low(input logic [1:0] idx);
    logic [NUM_CE-1:0] v;
    v    = '0;
    v[0] = 1'b1;
    return ~(v << idx);
  endfunction

  assign ce_sel     = (int'(ins_ce) < NUM_CE) ? ins_ce : 2'd0;
  assign busy       = (state != S_IDLE);
  assign flash_data = data_oe ? wdata_q : IDLE_PAT;

`ifdef FLASH_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(T_TO - 1);
  logic [15:0] to_cnt;
`else
  logic unused_to;
  assign unused_to   = (T_TO == 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    rd_valid <= 1'b0;
    if (rst) begin
      state     <= S_IDLE;
      mode      <= 3'd0;
      beats     <= 12'd0;
      ce_idx    <= 2'd0;
      ce_switch <= 1'b0;
      tmr       <= 4'd0;
      wdata_q   <= '0;
      oCE_N     <= '1;
      oCLE      <= 1'b0;
      oALE      <= 1'b0;
      oWE_N     <= 1'b1;
      oRE_N     <= 1'b1;
      oWP_N     <= 1'b0;
      data_oe   <= 1'b0;
      ins_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_data   <= '0;
`ifdef FLASH_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
`ifdef FLASH_SEQ_TIMEOUT_EN
      if (state != S_WAIT_RB) to_cnt <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (ce_switch) begin
            // Second IDLE cycle of a chip change: all CE_N were high for one cycle.
            ce_switch <= 1'b0;
            state     <= S_LOAD;
            oCE_N     <= ce_low(ce_idx);
            oCLE      <= (mode == M_CMD);
            oALE      <= (mode == M_ADDR);
          end else if (ins_valid && ins_ready) begin
            ins_ready <= 1'b0;
            mode      <= ins_mode;
            beats     <= ins_count;
            if (ins_mode == M_RSVD) begin
              state <= S_LOAD;
            end else begin
              ce_idx <= ce_sel;
              if (oCE_N != '1 && ce_sel != ce_idx) begin
                ce_switch <= 1'b1;
                oCE_N     <= '1;
              end else begin
                state <= S_LOAD;
                oCE_N <= ce_low(ce_sel);
                oCLE  <= (ins_mode == M_CMD);
                oALE  <= (ins_mode == M_ADDR);
              end
            end
          end else begin
            ins_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          case (mode)
            M_DOUT: begin
              state <= S_STROBE_LO;
              oRE_N <= 1'b0;
              tmr   <= LO_INIT;
            end
            M_WAIT_RB: begin
              state <= S_WAIT_RB;
              oCLE  <= 1'b0;
              oALE  <= 1'b0;
            end
            M_WP_ON, M_WP_OFF, M_RSVD: begin
              if (mode != M_RSVD) oWP_N <= (mode == M_WP_OFF);
              state     <= S_IDLE;
              ins_ready <= 1'b1;
            end
            default: begin
              state    <= S_WAIT_DATA;
              wr_ready <= 1'b1;
            end
          endcase
        end
        S_WAIT_DATA: begin
          if (wr_valid) begin
            wdata_q  <= wr_data;
            data_oe  <= 1'b1;
            wr_ready <= 1'b0;
            oWE_N    <= 1'b0;
            tmr      <= LO_INIT;
            state    <= S_STROBE_LO;
          end
        end
        S_STROBE_LO: begin
          if (tmr == 4'd0) begin
            oWE_N <= 1'b1;
            oRE_N <= 1'b1;
            tmr   <= HI_INIT;
            state <= S_STROBE_HI;
            if (mode == M_DOUT) begin
              rd_data  <= flash_q;
              rd_valid <= 1'b1;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_STROBE_HI: begin
          if (tmr != 4'd0) begin
            tmr <= tmr - 1'b1;
          end else if (beats == 12'd0) begin
            state     <= S_IDLE;
            ins_ready <= 1'b1;
            data_oe   <= 1'b0;
            oCLE      <= 1'b0;
            oALE      <= 1'b0;
          end else begin
            beats <= beats - 1'b1;
            if (mode == M_DOUT) begin
              state <= S_STROBE_LO;
              oRE_N <= 1'b0;
              tmr   <= LO_INIT;
            end else begin
              state    <= S_WAIT_DATA;
              wr_ready <= 1'b1;
            end
          end
        end
        S_WAIT_RB: begin
          if (iRB_N) begin
            state     <= S_IDLE;
            ins_ready <= 1'b1;
          end
`ifdef FLASH_SEQ_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
            ins_ready   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_seq.sv
// tb/tb_flash_seq.sv - scoreboard bench for flash_seq
module tb_flash_seq;
  localparam int DW = 8, NUM_CE = 2, T_LO = 2, T_HI = 2, T_TO = 50;
`ifdef FLASH_SEQ_TIMEOUT_EN
  localparam int RB_WAIT = 30;
`else
  localparam int RB_WAIT = 100;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic ins_valid, ins_ready, wr_valid, wr_ready, rd_valid, busy, timeout_err;
  logic [2:0] ins_mode;
  logic [11:0] ins_count;
  logic [1:0] ins_ce;
  logic [DW-1:0] wr_data, rd_data, flash_data;
  logic [DW-1:0] flash_q = '0;
  logic [NUM_CE-1:0] oCE_N;
  logic oCLE, oALE, oWE_N, oRE_N, oWP_N, iRB_N, data_oe;

  always #5 clk = ~clk;

  flash_seq #(.DW(DW), .NUM_CE(NUM_CE), .T_LO(T_LO), .T_HI(T_HI), .T_TO(T_TO)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_mode(ins_mode),
    .ins_count(ins_count), .ins_ce(ins_ce), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .timeout_err(timeout_err), .oCE_N(oCE_N), .oCLE(oCLE), .oALE(oALE), .oWE_N(oWE_N),
    .oRE_N(oRE_N), .oWP_N(oWP_N), .iRB_N(iRB_N), .flash_q(flash_q),
    .flash_data(flash_data), .data_oe(data_oe)
  );

  int n_checks = 0, n_fail = 0, viol = 0, we_lo = 0, re_lo = 0, n = 0;
  logic [DW+1:0] exp_wr[$];
  logic [DW-1:0] exp_rd[$], rd_src[$], tx_q[$];
  logic [DW+1:0] e_wr;
  logic [DW-1:0] e_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash read model: each RE_N fall presents the next queued byte.
  always @(negedge oRE_N) if (rd_src.size() != 0) flash_q = rd_src.pop_front();

  always @(negedge clk) begin
    if (rst) begin
      we_lo = 0;
      re_lo = 0;
    end else begin
      if (!oWE_N) begin
        if (we_lo == 0) begin
          if (exp_wr.size() == 0) check("wr_unexpected", exp_wr.size(), 1);
          else begin
            e_wr = exp_wr.pop_front();
            check("wr_beat", 32'({oCLE, oALE, flash_data}), 32'(e_wr));
            check("wr_oe", 32'(data_oe), 1);
          end
        end
        we_lo++;
      end else if (we_lo != 0) begin
        check("we_lo_width", we_lo, T_LO);
        we_lo = 0;
      end
      if (!oRE_N) re_lo++;
      else if (re_lo != 0) begin
        check("re_lo_width", re_lo, T_LO);
        re_lo = 0;
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) check("rd_unexpected", exp_rd.size(), 1);
        else begin
          e_rd = exp_rd.pop_front();
          check("rd_beat", 32'(rd_data), 32'(e_rd));
        end
      end
      if (ins_ready && wr_ready) viol++;
    end
  end

  task automatic issue(input logic [2:0] m, input logic [11:0] c, input logic [1:0] ce);
    int w = 0;
    @(negedge clk);
    while (!ins_ready && w < 200) begin @(negedge clk); w++; end
    if (!ins_ready) check("issue_timeout", w, 0);
    ins_valid = 1'b1; ins_mode = m; ins_count = c; ins_ce = ce;
    @(posedge clk); #1;
    ins_valid = 1'b0;
  endtask

  task automatic send_beats(input int cnt, input int stall_at, input logic cle, input logic ale);
    for (int i = 0; i < cnt; i++) begin
      int w = 0;
      @(negedge clk);
      while (!wr_ready && w < 100) begin @(negedge clk); w++; end
      if (!wr_ready) begin check("wr_ready_timeout", w, 0); return; end
      if (i == stall_at) begin
        repeat (3) begin check("stall_we_high", 32'(oWE_N), 1); @(negedge clk); end
        check("stall_hold", 32'(wr_ready), 1);
      end
      wr_data = tx_q[i]; wr_valid = 1'b1;
      exp_wr.push_back({cle, ale, tx_q[i]});
      @(posedge clk); #1;
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((busy || !ins_ready) && w < 10000) begin @(negedge clk); w++; end
    if (busy || !ins_ready) check("idle_timeout", w, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_valid = 0; ins_mode = 0; ins_count = 0; ins_ce = 0;
    wr_data = 0; wr_valid = 0; iRB_N = 1;
    repeat (2) @(posedge clk); #1;
    check("rst_ce", 32'(oCE_N), 32'b11);
    check("rst_pins", 32'({oCLE, oALE, oWE_N, oRE_N, oWP_N}), 32'b00110);
    check("rst_ctl", 32'({ins_ready, wr_ready, rd_valid, busy, data_oe, timeout_err}), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_fdata", 32'(flash_data), 32'hAA);
    rst = 0;
    @(posedge clk); #1;
    check("idle_ready", 32'(ins_ready), 1);

    // CMD 0x70: LOAD, WAIT_DATA, 2 low, 2 high
    wr_data = 8'h70; wr_valid = 1; exp_wr.push_back({2'b10, 8'h70});
    issue(3'd0, 12'd0, 2'd0);
    n = 0;
    while (busy && n < 50) begin @(posedge clk); #1; n++; end
    wr_valid = 0;
    check("cmd_cycles", n, 6);
    check("cmd_ce", 32'(oCE_N), 32'b10);
    check("cmd_release", 32'({oCLE, data_oe, flash_data}), 32'h0AA);

    // ADDR 5 beats with a 3-cycle stall before the third
    tx_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    fork
      issue(3'd1, 12'd4, 2'd0);
      send_beats(5, 2, 1'b0, 1'b1);
    join
    wait_idle();
    check("addr_drained", exp_wr.size(), 0);

    // DIN on chip 1: one all-high IDLE cycle before CE1 drops
    tx_q.delete();
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
    fork
      begin
        issue(3'd2, 12'd2, 2'd1);
        check("ce_gap", 32'(oCE_N), 32'b11);
        check("ce_gap_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("ce_new", 32'(oCE_N), 32'b01);
      end
      send_beats(3, -1, 1'b0, 1'b0);
    join
    wait_idle();
    check("din_drained", exp_wr.size(), 0);

    // DOUT 4 beats from the flash model
    rd_src = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_rd = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue(3'd3, 12'd3, 2'd1);
    wait_idle();
    check("dout_drained", exp_rd.size(), 0);
    check("dout_ce_kept", 32'(oCE_N), 32'b01);

    // Out-of-range ce maps to chip 0
    for (int i = 0; i < 2; i++) begin
      e_rd = 8'($urandom);
      rd_src.push_back(e_rd);
      exp_rd.push_back(e_rd);
    end
    issue(3'd3, 12'd1, 2'd3);
    wait_idle();
    check("dout2_drained", exp_rd.size(), 0);
    check("ce_clamp", 32'(oCE_N), 32'b10);

    // Write protect off persists across a CMD; reserved mode changes nothing
    issue(3'd6, 12'd0, 2'd0);
    wait_idle();
    check("wp_off", 32'(oWP_N), 1);
    wr_data = 8'h90; wr_valid = 1; exp_wr.push_back({2'b10, 8'h90});
    issue(3'd0, 12'd0, 2'd0);
    wait_idle();
    wr_valid = 0;
    check("wp_persist", 32'(oWP_N), 1);
    issue(3'd7, 12'd0, 2'd1);
    wait_idle();
    check("rsvd_pins", 32'({oCE_N, oWP_N, oCLE, oALE}), 32'b10_1_0_0);

    // WAIT_RB released by iRB_N
    iRB_N = 0;
    issue(3'd4, 12'd0, 2'd0);
    n = 0;
    for (int i = 0; i < RB_WAIT; i++) begin
      if (busy) n++;
      @(posedge clk); #1;
    end
    check("rb_busy_cycles", n, RB_WAIT);
    iRB_N = 1;
    @(posedge clk); #1;
    check("rb_exit", 32'(busy), 0);
    check("rb_no_timeout", 32'(timeout_err), 0);

`ifdef FLASH_SEQ_TIMEOUT_EN
    iRB_N = 0;
    issue(3'd4, 12'd0, 2'd0);
    n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    check("to_cycles", n, T_TO + 1);
    check("to_flag", 32'(timeout_err), 1);
    iRB_N = 1;
    issue(3'd6, 12'd0, 2'd0);
    wait_idle();
    check("to_sticky", 32'(timeout_err), 1);
`endif

    // Reset during DIN strobe low
    wr_data = 8'h5C; wr_valid = 1; exp_wr.push_back({2'b00, 8'h5C});
    issue(3'd2, 12'd0, 2'd0);
    n = 0;
    while (oWE_N && n < 20) begin @(negedge clk); n++; end
    check("abort_reach_lo", 32'(oWE_N), 0);
    @(posedge clk); #1;
    rst = 1; wr_valid = 0;
    @(posedge clk); #1;
    check("abort_pins", 32'({oWE_N, data_oe, oCE_N, oWP_N}), 32'b1_0_11_0);
    check("abort_ctl", 32'({busy, timeout_err, ins_ready, wr_ready}), 0);
    @(posedge clk); #1;
    rst = 0;

    // Recovery after reset
    wr_data = 8'hFF; wr_valid = 1; exp_wr.push_back({2'b10, 8'hFF});
    issue(3'd0, 12'd0, 2'd1);
    wait_idle();
    wr_valid = 0;
    check("recover_ce", 32'(oCE_N), 32'b01);
    check("final_wr_drained", exp_wr.size(), 0);
    check("final_rd_drained", exp_rd.size(), 0);
    check("ready_exclusive", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
